// File: rtl/rf_pkg.sv
// Shared widths and state encoding for the register-file write-port controller.
// REGFILE_CLEAR_EN (see regfile_wport_arbiter) selects the post-reset clear sequence.
package rf_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_REGS = 2 ** AW;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Index width for an n-entry requester vector, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// searching upward modulo NUM_REQ, gets a one-hot grant and its index.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   grant_idx,
    output logic                        grant_valid
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    logic [IW:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // ptr < NUM_REQ, so one conditional subtract performs the modulo.
            cand = {1'b0, ptr} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(NUM_REQ)) begin
                cand = cand - (IW + 1)'(NUM_REQ);
            end
            if (!grant_valid && req[IW'(cand)]) begin
                grant_valid       = 1'b1;
                grant_idx         = IW'(cand);
                grant[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single write port of the 32 x XLEN register file shared by NUM_REQ writeback
// requesters. Define REGFILE_CLEAR_EN to zero every register after reset.
module regfile_wport_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*XLEN-1:0]  req_data,
    output logic                     rf_write_enable,
    output logic [AW-1:0]            rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     init_busy
);

    localparam int unsigned IW = idx_w(NUM_REQ);

    logic [IW-1:0]       rr_ptr_q;
    logic [IW-1:0]       rr_ptr_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_valid;
    logic                run_c;
    logic                xfer;
    logic [AW-1:0]       sel_addr;
    logic [XLEN-1:0]     sel_data;

`ifdef REGFILE_CLEAR_EN
    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            init_busy_q;

    assign run_c     = (state_q == RUN);
    assign init_busy = init_busy_q;
`else
    assign run_c     = 1'b1;
    assign init_busy = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Ready is the only combinational output; nothing from req_* reaches rf_*.
    assign req_ready  = run_c ? grant : '0;
    assign xfer       = run_c & grant_valid;
    assign rr_ptr_nxt = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);

    // Payload of the granted requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // FSM, round-robin pointer and registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write_enable <= 1'b0;
            rf_waddr        <= '0;
            rf_wdata        <= '0;
            rr_ptr_q        <= '0;
`ifdef REGFILE_CLEAR_EN
            state_q         <= INIT;
            clr_cnt_q       <= '0;
            init_busy_q     <= 1'b1;
`endif
        end else begin
`ifdef REGFILE_CLEAR_EN
            if (state_q == INIT) begin
                rf_write_enable <= 1'b1;
                rf_waddr        <= clr_cnt_q;
                rf_wdata        <= '0;
                if (clr_cnt_q == AW'(NUM_REGS - 1)) begin
                    state_q     <= RUN;
                    init_busy_q <= 1'b0;
                end else begin
                    clr_cnt_q   <= clr_cnt_q + AW'(1);
                end
            end else
`endif
            if (xfer) begin
                // x0 is hardwired zero: accept the write but never enable it.
                rf_write_enable <= (sel_addr != '0);
                rf_waddr        <= sel_addr;
                rf_wdata        <= sel_data;
                rr_ptr_q        <= rr_ptr_nxt;
            end else begin
                rf_write_enable <= 1'b0;
            end
        end
    end

endmodule
